bomb_countdown_ctrl: RTL and testbench
======================================

BOMB_COUNTDOWN_CTRL -- requirements
Module: bomb_countdown_ctrl

Interface
REQ-001 SHALL have parameter SEC_WIDTH, default 8, width of the seconds counter and load value.
REQ-002 SHALL have parameter CODE_WIDTH, default 4, width of the defuse code.
REQ-003 SHALL have parameter MAX_TRIES, default 3, wrong code entries that cause explosion; legal range 1..7.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port sync_reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port arm  input  1  single-cycle request to start a countdown.
REQ-007 SHALL have port load_seconds  input  SEC_WIDTH  countdown length, sampled with arm.
REQ-008 SHALL have port arm_code  input  CODE_WIDTH  defuse code, sampled with arm.
REQ-009 SHALL have port code_valid  input  1  single-cycle strobe qualifying code_in.
REQ-010 SHALL have port code_in  input  CODE_WIDTH  entered defuse code.
REQ-011 SHALL have port ack  input  1  operator acknowledge, returns a finished bomb to IDLE.
REQ-012 SHALL have port half_second  input  1  one-cycle tick from the timer, every 0.5 s.
REQ-013 SHALL have port second  input  1  one-cycle tick from the timer, every 1 s, coincident with every second half_second.
REQ-014 SHALL have port timer_enable  output  1  drives timer enabled.
REQ-015 SHALL have port timer_clear  output  1  drives timer clear.
REQ-016 SHALL have port seconds_left  output  SEC_WIDTH  remaining seconds.
REQ-017 SHALL have port beep  output  1  one-cycle beeper pulse.
REQ-018 SHALL have port state  output  2  IDLE=0, ARMED=1, DEFUSED=2, EXPLODED=3.

Function
REQ-019 SHALL implement a four-state FSM: IDLE, ARMED, DEFUSED, EXPLODED.
REQ-020 SHALL drive timer_enable=1, timer_clear=0 only in ARMED; all other states timer_enable=0, timer_clear=1 (decoded from state register, no extra latency).
REQ-021 IDLE: arm=1 with load_seconds!=0 SHALL load seconds_left, store arm_code, zero the try counter, enter ARMED next cycle; arm with load_seconds==0 SHALL be ignored.
REQ-022 SHALL ignore arm in every state other than IDLE; SHALL ignore code_valid and ticks outside ARMED.
REQ-023 ARMED, second=1, no code_valid: seconds_left SHALL decrement by 1; if seconds_left was 1 it SHALL become 0 and state SHALL go to EXPLODED.
REQ-024 ARMED, code_valid=1 with code_in==stored code: state SHALL go to DEFUSED next cycle, seconds_left frozen at current value; this SHALL take priority over a same-cycle second tick.
REQ-025 ARMED, code_valid=1 with wrong code: try counter SHALL increment; if it reaches MAX_TRIES state SHALL go to EXPLODED; otherwise seconds_left SHALL be halved (logical shift right by 1).
REQ-026 Wrong code coincident with second: SHALL apply decrement first, then halve; if result is 0, state SHALL go to EXPLODED.
REQ-027 Halving a value of 1 (no tick) SHALL yield 0 and go to EXPLODED.
REQ-028 beep SHALL pulse one cycle after a second tick in ARMED while seconds_left>10, and one cycle after every half_second tick in ARMED while seconds_left<=10 (value before update).
REQ-029 beep SHALL pulse one cycle on the cycle of entry to EXPLODED (registered, one-cycle latency from the causing event); no beep on entry to DEFUSED.
REQ-030 DEFUSED and EXPLODED SHALL hold seconds_left and state until ack=1, then go to IDLE next cycle; seconds_left SHALL read 0 in IDLE.
REQ-031 Arithmetic SHALL be unsigned SEC_WIDTH; seconds_left SHALL never wrap below 0.

Reset
REQ-032 sync_reset=1 at a rising edge SHALL force state=IDLE, seconds_left=0, beep=0, try counter=0, stored code=0, hence timer_enable=0, timer_clear=1, in any state including mid-countdown.
REQ-033 sync_reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 arm, load_seconds=3, then 3 second ticks -> seconds_left 2,1,0; state EXPLODED after third tick; beep on each tick plus explosion.
REQ-035 arm, load_seconds=20, arm_code=5; after 2 ticks code_in=5 with same-cycle second -> state DEFUSED, seconds_left=18, timer_clear=1.
REQ-036 arm, load_seconds=40, code 9; wrong code 3 -> seconds_left=20; wrong code 4 with second -> 9; third wrong -> EXPLODED.
REQ-037 seconds_left=10 in ARMED, half_second ticks at 0.5 s spacing -> beep once per half_second; at seconds_left=11 -> beep only on second.
REQ-038 arm with load_seconds=0 -> stays IDLE; sync_reset mid-ARMED at seconds_left=7 -> IDLE, seconds_left=0, timer_enable=0 next cycle.
REQ-039 EXPLODED then ack=1 -> IDLE next cycle; subsequent arm, load_seconds=5 -> ARMED, seconds_left=5.

Source files
------------

// File: rtl/bomb_countdown_ctrl.sv
// rtl/bomb_countdown_ctrl.sv - countdown/defuse controller with beeper and timer control
module bomb_countdown_ctrl #(
   parameter int SEC_WIDTH  = 8,
   parameter int CODE_WIDTH = 4,
   parameter int MAX_TRIES  = 3
) (
   input  logic                  clk,
   input  logic                  sync_reset,
   input  logic                  arm,
   input  logic [SEC_WIDTH-1:0]  load_seconds,
   input  logic [CODE_WIDTH-1:0] arm_code,
   input  logic                  code_valid,
   input  logic [CODE_WIDTH-1:0] code_in,
   input  logic                  ack,
   input  logic                  half_second,
   input  logic                  second,
   output logic                  timer_enable,
   output logic                  timer_clear,
   output logic [SEC_WIDTH-1:0]  seconds_left,
   output logic                  beep,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_DEFUSED  = 2'd2,
      ST_EXPLODED = 2'd3
   } state_t;

   localparam logic [2:0]           TRIES_LIMIT     = 3'(MAX_TRIES);
   localparam logic [SEC_WIDTH-1:0] SEC_ONE         = SEC_WIDTH'(1);
   localparam logic [SEC_WIDTH-1:0] BEEP_FAST_LIMIT = SEC_WIDTH'(10);

   state_t                cur_state;
   logic [CODE_WIDTH-1:0] stored_code;
   logic [2:0]            tries;

   logic [SEC_WIDTH-1:0]  sec_dec;
   logic [SEC_WIDTH-1:0]  sec_half;
   logic [2:0]            tries_next;
   logic                  code_match;
   logic                  tick_beep;

   assign state        = cur_state;
   assign timer_enable = (cur_state == ST_ARMED);
   assign timer_clear  = (cur_state != ST_ARMED);

   // A wrong code on a tick cycle halves the already-decremented value.
   always_comb begin
      sec_dec    = (second && seconds_left != '0) ? seconds_left - SEC_ONE : seconds_left;
      sec_half   = sec_dec >> 1;
      tries_next = tries + 3'd1;
      code_match = (code_in == stored_code);
      tick_beep  = (second && seconds_left > BEEP_FAST_LIMIT) ||
                   (half_second && seconds_left <= BEEP_FAST_LIMIT);
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         cur_state    <= ST_IDLE;
         seconds_left <= '0;
         beep         <= 1'b0;
         tries        <= '0;
         stored_code  <= '0;
      end else begin
         beep <= 1'b0;
         case (cur_state)
            ST_IDLE: begin
               if (arm && load_seconds != '0) begin
                  seconds_left <= load_seconds;
                  stored_code  <= arm_code;
                  tries        <= '0;
                  cur_state    <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (code_valid && code_match) begin
                  cur_state <= ST_DEFUSED;
               end else if (code_valid) begin
                  tries <= tries_next;
                  if (tries_next >= TRIES_LIMIT) begin
                     seconds_left <= sec_dec;
                     cur_state    <= ST_EXPLODED;
                     beep         <= 1'b1;
                  end else begin
                     seconds_left <= sec_half;
                     if (sec_half == '0) begin
                        cur_state <= ST_EXPLODED;
                        beep      <= 1'b1;
                     end else begin
                        beep <= tick_beep;
                     end
                  end
               end else if (second) begin
                  seconds_left <= sec_dec;
                  if (sec_dec == '0) begin
                     cur_state <= ST_EXPLODED;
                     beep      <= 1'b1;
                  end else begin
                     beep <= tick_beep;
                  end
               end else begin
                  beep <= tick_beep;
               end
            end
            ST_DEFUSED, ST_EXPLODED: begin
               if (ack) begin
                  cur_state    <= ST_IDLE;
                  seconds_left <= '0;
               end
            end
            default: cur_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bomb_countdown_ctrl.sv
// tb/tb_bomb_countdown_ctrl.sv - scoreboard bench for bomb_countdown_ctrl
module tb_bomb_countdown_ctrl;

   logic       clk = 1'b0;
   logic       sync_reset;
   logic       arm;
   logic [7:0] load_seconds;
   logic [3:0] arm_code;
   logic       code_valid;
   logic [3:0] code_in;
   logic       ack;
   logic       half_second;
   logic       second;
   logic       timer_enable;
   logic       timer_clear;
   logic [7:0] seconds_left;
   logic       beep;
   logic [1:0] state;

   localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, DEFUSED = 2'd2, EXPLODED = 2'd3;

   typedef struct {
      logic [1:0] st;
      int         sl;   // -1: value not constrained
      logic       bp;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   bomb_countdown_ctrl dut (
      .clk          (clk),
      .sync_reset   (sync_reset),
      .arm          (arm),
      .load_seconds (load_seconds),
      .arm_code     (arm_code),
      .code_valid   (code_valid),
      .code_in      (code_in),
      .ack          (ack),
      .half_second  (half_second),
      .second       (second),
      .timer_enable (timer_enable),
      .timer_clear  (timer_clear),
      .seconds_left (seconds_left),
      .beep         (beep),
      .state        (state)
   );

   task automatic cmp(input string nm, input string fld, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
      end
   endtask

   // Monitor: the DUT presents a fresh registered result after every edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         cmp(nm, "state", int'(state), int'(e.st));
         if (e.sl >= 0) cmp(nm, "seconds_left", int'(seconds_left), e.sl);
         cmp(nm, "beep", int'(beep), int'(e.bp));
         cmp(nm, "timer_enable", int'(timer_enable), (e.st == ARMED) ? 1 : 0);
         cmp(nm, "timer_clear", int'(timer_clear), (e.st == ARMED) ? 0 : 1);
      end
   end

   task automatic clear_inputs();
      sync_reset   = 1'b0;
      arm          = 1'b0;
      load_seconds = 8'd0;
      arm_code     = 4'd0;
      code_valid   = 1'b0;
      code_in      = 4'd0;
      ack          = 1'b0;
      half_second  = 1'b0;
      second       = 1'b0;
   endtask

   // Apply the currently driven inputs for one edge and queue the expected result.
   task automatic step(input string nm, input logic [1:0] st, input int sl, input logic bp);
      exp_t e;
      @(posedge clk);
      e.st = st;
      e.sl = sl;
      e.bp = bp;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic do_arm(input logic [7:0] ld, input logic [3:0] cd);
      arm          = 1'b1;
      load_seconds = ld;
      arm_code     = cd;
   endtask

   task automatic do_tick();
      second      = 1'b1;
      half_second = 1'b1;
   endtask

   task automatic do_code(input logic [3:0] c);
      code_valid = 1'b1;
      code_in    = c;
   endtask

   initial begin
      clear_inputs();
      sync_reset = 1'b1;
      step("reset", IDLE, 0, 0);
      do_tick();
      step("idle_tick_ignored", IDLE, 0, 0);

      // Countdown to explosion from 3
      do_arm(8'd3, 4'd1);
      step("a_arm", ARMED, 3, 0);
      do_tick();            step("a_tick1", ARMED, 2, 1);
      step("a_gap1", ARMED, 2, 0);
      do_tick();            step("a_tick2", ARMED, 1, 1);
      step("a_gap2", ARMED, 1, 0);
      do_tick();            step("a_tick3", EXPLODED, 0, 1);
      step("a_hold", EXPLODED, 0, 0);
      do_arm(8'd9, 4'd2);   step("a_arm_ignored", EXPLODED, 0, 0);
      ack = 1'b1;           step("a_ack", IDLE, 0, 0);

      // Correct code beats a same-cycle tick
      do_arm(8'd20, 4'd5);  step("b_arm", ARMED, 20, 0);
      do_tick();            step("b_tick1", ARMED, 19, 1);
      do_tick();            step("b_tick2", ARMED, 18, 1);
      do_tick(); do_code(4'd5);
      step("b_defuse", DEFUSED, 18, 0);
      do_code(4'd0); do_tick();
      step("b_defused_hold", DEFUSED, 18, 0);
      ack = 1'b1;           step("b_ack", IDLE, 0, 0);

      // Wrong codes: halve, decrement-then-halve, then too many tries
      do_arm(8'd40, 4'd9);  step("c_arm", ARMED, 40, 0);
      do_code(4'd3);        step("c_wrong1", ARMED, 20, 0);
      do_code(4'd4); do_tick();
      step("c_wrong2_tick", ARMED, 9, 1);
      do_code(4'd1);        step("c_wrong3", EXPLODED, -1, 1);
      ack = 1'b1;           step("c_ack", IDLE, 0, 0);

      // Beep rate switches at the 10-second boundary
      do_arm(8'd11, 4'd7);  step("d_arm", ARMED, 11, 0);
      half_second = 1'b1;   step("d_half_at11", ARMED, 11, 0);
      do_tick();            step("d_sec_at11", ARMED, 10, 1);
      half_second = 1'b1;   step("d_half_at10", ARMED, 10, 1);
      do_tick();            step("d_sec_at10", ARMED, 9, 1);
      half_second = 1'b1;   step("d_half_at9", ARMED, 9, 1);
      do_tick();            step("d_sec_at9", ARMED, 8, 1);
      do_tick();            step("d_sec_at8", ARMED, 7, 1);
      sync_reset = 1'b1; do_tick(); do_code(4'd7);
      step("d_reset_mid", IDLE, 0, 0);
      do_arm(8'd0, 4'd3);   step("d_arm_zero", IDLE, 0, 0);

      // Halving 1 explodes, then re-arm after ack
      do_arm(8'd1, 4'd2);   step("e_arm", ARMED, 1, 0);
      do_code(4'd6);        step("e_halve_one", EXPLODED, 0, 1);
      ack = 1'b1;           step("e_ack", IDLE, 0, 0);
      do_arm(8'd5, 4'd2);   step("e_rearm", ARMED, 5, 0);
      ack = 1'b1;           step("e_ack_ignored", ARMED, 5, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
